// File: rtl/status_seq_pkg.sv
// Shared types for the status lookup sequencer: FSM encoding, request record, stats width.
package status_seq_pkg;

  localparam int unsigned SEQ_ADDR_W = 8;
  localparam int unsigned SEQ_TAG_W  = 4;
  localparam int unsigned STATS_W    = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;

  typedef struct packed {
    logic [SEQ_TAG_W-1:0]  tag;
    logic [SEQ_ADDR_W-1:0] addr;
  } seq_req_t;

endpackage

// File: rtl/status_seq_if.sv
// Request, lookup-strobe and response channels of the status lookup sequencer.
interface status_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_active;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [TAG_W-1:0]  rsp_tag;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_active;

  modport slave (
    input  req_valid, req_addr, req_tag, lk_active, rsp_ready,
    output req_ready, lk_valid, lk_addr, rsp_valid, rsp_tag, rsp_addr, rsp_active
  );

  modport master (
    output req_valid, req_addr, req_tag, lk_active, rsp_ready,
    input  req_ready, lk_valid, lk_addr, rsp_valid, rsp_tag, rsp_addr, rsp_active
  );
endinterface

// File: rtl/status_seq_fifo.sv
// Synchronous request FIFO; pointers wrap modulo DEPTH, caller must not push when full or pop when empty.
module status_seq_fifo import status_seq_pkg::*; #(
  parameter type         T     = seq_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned PW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/status_lookup_sequencer.sv
// Buffers tagged lookups, issues one strobe at a time, returns {tag, addr, active}.
// Optional STATUS_SEQ_STATS_EN adds saturating hit/miss counters.
module status_lookup_sequencer import status_seq_pkg::*; #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  status_seq_if.slave            bus,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef STATUS_SEQ_STATS_EN
  ,
  output logic [STATS_W-1:0]     hit_cnt,
  output logic [STATS_W-1:0]     miss_cnt
`endif
);
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
  } req_t;

  seq_state_t        r_state;
  seq_state_t        w_next;
  req_t              w_push_data;
  req_t              w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic              r_rsp_active;

  // No full-with-pop bypass: a full FIFO refuses even while ISSUE pops.
  assign w_push_data = '{tag: bus.req_tag, addr: bus.req_addr};
  assign w_push      = bus.req_valid && !w_full;
  assign bus.req_ready = !w_full;

  status_seq_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    bus.lk_valid  = 1'b0;
    bus.lk_addr   = '0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE:  if (!w_empty) w_next = ISSUE;
      ISSUE: begin
        w_pop        = 1'b1;
        bus.lk_valid = 1'b1;
        bus.lk_addr  = w_head.addr;
        w_next       = WAIT;
      end
      WAIT:  w_next = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = w_empty ? IDLE : ISSUE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rsp_tag    <= '0;
      r_rsp_addr   <= '0;
      r_rsp_active <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ISSUE) begin
        r_rsp_tag  <= w_head.tag;
        r_rsp_addr <= w_head.addr;
      end
      if (r_state == WAIT) r_rsp_active <= bus.lk_active;
    end
  end

  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_addr   = r_rsp_addr;
  assign bus.rsp_active = r_rsp_active;

`ifdef STATUS_SEQ_STATS_EN
  logic [STATS_W-1:0] r_hit_cnt;
  logic [STATS_W-1:0] r_miss_cnt;
  logic               w_rsp_hs;

  assign w_rsp_hs = (r_state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_rsp_hs) begin
      if (r_rsp_active) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_status_lookup_sequencer.sv
// Self-checking bench for status_lookup_sequencer: vector table, response scoreboard, corner sequences.
module tb_status_lookup_sequencer;
  import status_seq_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] tag;
    logic       active;
  } vec_t;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] addr;
    logic       active;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fifo_count;
`ifdef STATUS_SEQ_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_push = 0;
  int          cyc = 0;
  logic        lk_en = 1'b0;
  exp_t        sb[$];
  int          lk_q[$];
  vec_t        tbl[10];

  status_seq_if #(.ADDR_W(8), .TAG_W(4)) ifc ();

  status_lookup_sequencer #(.ADDR_W(8), .TAG_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .fifo_count (fifo_count)
`ifdef STATUS_SEQ_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lookup block model: registered result, even addresses are present.
  always @(posedge clk or posedge reset) begin
    if (reset) ifc.lk_active <= 1'b0;
    else       ifc.lk_active <= ifc.lk_valid && !ifc.lk_addr[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response and strobe monitor, sampled just before the rising edge.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!reset && ifc.rsp_valid && ifc.rsp_ready) begin
      chk("rsp_sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_tag",    32'(ifc.rsp_tag),    32'(e.tag));
        chk("rsp_addr",   32'(ifc.rsp_addr),   32'(e.addr));
        chk("rsp_active", 32'(ifc.rsp_active), 32'(e.active));
      end
    end
    if (!reset && lk_en && ifc.lk_valid) lk_q.push_back(cyc);
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input vec_t v);
    ifc.req_valid = 1'b1;
    ifc.req_addr  = v.addr;
    ifc.req_tag   = v.tag;
    for (int n = 0; n < 200 && !ifc.req_ready; n++) @(negedge clk);
    chk("req_accept", 32'(ifc.req_ready), 32'd1);
    if (ifc.req_ready) begin
      sb.push_back('{tag: v.tag, addr: v.addr, active: v.active});
      n_push++;
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    logic done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ifc.rsp_valid && !ifc.lk_valid && fifo_count == 3'd0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int unsigned base;
    logic [3:0]  h_tag;
    logic [7:0]  h_addr;
    logic        h_act;
    logic        found;

    tbl[0] = '{addr: 8'h10, tag: 4'h1, active: 1'b1};
    tbl[1] = '{addr: 8'h21, tag: 4'h2, active: 1'b0};
    tbl[2] = '{addr: 8'h32, tag: 4'h3, active: 1'b1};
    tbl[3] = '{addr: 8'h43, tag: 4'h4, active: 1'b0};
    tbl[4] = '{addr: 8'h54, tag: 4'h5, active: 1'b1};
    tbl[5] = '{addr: 8'h65, tag: 4'h6, active: 1'b0};
    tbl[6] = '{addr: 8'hA0, tag: 4'h7, active: 1'b1};
    tbl[7] = '{addr: 8'hB1, tag: 4'h8, active: 1'b0};
    tbl[8] = '{addr: 8'hC2, tag: 4'h9, active: 1'b1};
    tbl[9] = '{addr: 8'hD3, tag: 4'hA, active: 1'b0};

    reset = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_tag   = '0;
    ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(ifc.req_ready),  32'd1);
    chk("rst_lk_valid",   32'(ifc.lk_valid),   32'd0);
    chk("rst_rsp_valid",  32'(ifc.rsp_valid),  32'd0);
    chk("rst_rsp_tag",    32'(ifc.rsp_tag),    32'd0);
    chk("rst_rsp_addr",   32'(ifc.rsp_addr),   32'd0);
    chk("rst_rsp_active", 32'(ifc.rsp_active), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count),     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request: strobe in N+2, response in N+4.
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 8'h02;
    ifc.req_tag   = 4'h3;
    chk("t1_req_ready", 32'(ifc.req_ready), 32'd1);
    sb.push_back('{tag: 4'h3, addr: 8'h02, active: 1'b1});
    @(negedge clk);
    ifc.req_valid = 1'b0;
    chk("t1_lk_n1",   32'(ifc.lk_valid),  32'd0);
    @(negedge clk);
    chk("t1_lk_n2",   32'(ifc.lk_valid),  32'd1);
    chk("t1_lk_addr", 32'(ifc.lk_addr),   32'h02);
    @(negedge clk);
    chk("t1_lk_n3",   32'(ifc.lk_valid),  32'd0);
    chk("t1_rsp_n3",  32'(ifc.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_rsp_n4",  32'(ifc.rsp_valid), 32'd1);
    chk("t1_tag",     32'(ifc.rsp_tag),   32'd3);
    wait_drain("t1_drain");

    // Six requests against a stalled consumer: FIFO fills behind the one in flight.
    ifc.rsp_ready = 1'b0;
    base = n_push;
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i]);
      end
      begin
        repeat (12) @(negedge clk);
        chk("t2_fifo_full",   32'(fifo_count),    32'd4);
        chk("t2_req_ready",   32'(ifc.req_ready), 32'd0);
        chk("t2_accepted",    n_push - base,      32'd5);
        chk("t3_rsp_valid",   32'(ifc.rsp_valid), 32'd1);
        h_tag  = ifc.rsp_tag;
        h_addr = ifc.rsp_addr;
        h_act  = ifc.rsp_active;
        chk("t3_first_tag",   32'(h_tag),         32'(tbl[0].tag));
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("t3_tag_hold",    32'(ifc.rsp_tag),    32'(h_tag));
          chk("t3_addr_hold",   32'(ifc.rsp_addr),   32'(h_addr));
          chk("t3_active_hold", 32'(ifc.rsp_active), 32'(h_act));
          chk("t3_no_lk",       32'(ifc.lk_valid),   32'd0);
          chk("t3_count_hold",  32'(fifo_count),     32'd4);
        end
        chk("t2_still_5",     n_push - base,      32'd5);
        ifc.rsp_ready = 1'b1;
      end
    join
    chk("t2_accepted_all", n_push - base, 32'd6);
    wait_drain("t2_drain");

    // Back-to-back with a ready consumer: one strobe every 3 cycles.
    lk_q.delete();
    lk_en = 1'b1;
    for (int i = 6; i < 10; i++) send(tbl[i]);
    wait_drain("t4_drain");
    lk_en = 1'b0;
    chk("t4_lk_pulses", lk_q.size(), 32'd4);
    for (int i = 1; i < lk_q.size(); i++) chk("t4_lk_gap", 32'(lk_q[i] - lk_q[i-1]), 32'd3);

    // Reset while waiting on the lookup result.
    send('{addr: 8'h44, tag: 4'h1, active: 1'b1});
    send('{addr: 8'h55, tag: 4'h2, active: 1'b0});
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (ifc.lk_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_lk_seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("t5_in_wait", 32'(dut.r_state), 32'(WAIT));
    reset = 1'b1;
    #1;
    chk("t5_rsp_valid",  32'(ifc.rsp_valid),  32'd0);
    chk("t5_fifo_count", 32'(fifo_count),     32'd0);
    chk("t5_state",      32'(dut.r_state),    32'(IDLE));
    chk("t5_req_ready",  32'(ifc.req_ready),  32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send('{addr: 8'hFF, tag: 4'h5, active: 1'b0});
    wait_drain("t5_drain");

`ifdef STATUS_SEQ_STATS_EN
    send('{addr: 8'h04, tag: 4'h1, active: 1'b1});
    send('{addr: 8'h06, tag: 4'h2, active: 1'b1});
    wait_drain("t6_drain");
    chk("t6_hit_cnt",  32'(hit_cnt),  32'd2);
    chk("t6_miss_cnt", 32'(miss_cnt), 32'd1);
    force dut.r_hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
    send('{addr: 8'h08, tag: 4'h3, active: 1'b1});
    wait_drain("t6_sat_drain");
    chk("t6_hit_sat",  32'(hit_cnt),  32'hFFFF);
    chk("t6_miss_sat", 32'(miss_cnt), 32'd1);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
